// File: rtl/merge_2_1_rr.sv
// merge_2_1_rr: two-channel valid/ready merge with round-robin arbitration.
// Accepted beats go into one output register that carries the source channel.
// Each input channel has a wrapping 8-bit counter of beats accepted from it.
module merge_2_1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] a1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_src,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    logic ld;       // output register can take a new beat this cycle
    logic last;     // channel granted most recently
    logic gnt_any;  // some channel is requesting
    logic gnt_ch;   // granted channel, meaningful only when gnt_any is high
    logic xfer;     // a beat moves into the output register at this edge

    // Round-robin grant: a single requester always wins; on a tie the
    // channel that did not win last time is chosen.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_any = v0 | v1;
        gnt_ch  = 1'b0;
        if (v0 && v1) begin
            gnt_ch = ~last;
        end else if (v1) begin
            gnt_ch = 1'b1;
        end
    end

    assign ld   = !y_valid || y_ready;
    assign xfer = ld && !rst && gnt_any;
    assign r0   = xfer && !gnt_ch;
    assign r1   = xfer && gnt_ch;

    // Output register, arbitration history and per-channel beat counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before this edge.
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_src   <= 1'b0;
            last    <= 1'b1;  // channel 0 wins the first tie
            cnt0    <= 8'd0;
            cnt1    <= 8'd0;
        end else if (ld) begin
            if (xfer) begin
                y       <= gnt_ch ? a1 : a0;
                y_src   <= gnt_ch;
                y_valid <= 1'b1;
                last    <= gnt_ch;
                if (gnt_ch) begin
                    cnt1 <= cnt1 + 8'd1;
                end else begin
                    cnt0 <= cnt0 + 8'd1;
                end
            end else begin
                // Draining with nothing to load: y and y_src keep the old beat.
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge_2_1_rr.sv
// Testbench for merge_2_1_rr: table-driven cycle vectors with expected
// readies and post-edge state, plus a scoreboard of accepted beats that is
// compared against each beat the downstream side takes.
module tb_merge_2_1_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a0, a1, y;
    logic       v0, v1, r0, r1, y_valid, y_ready, y_src;
    logic [7:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    // Expected beats {src, data} in acceptance order.
    logic [8:0] sb[$];

    typedef struct {
        logic       v0;
        logic [7:0] a0;
        logic       v1;
        logic [7:0] a1;
        logic       yr;
        logic       e_r0;
        logic       e_r1;
        logic       e_yv;
        logic [7:0] e_y;
        logic       e_src;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    merge_2_1_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a0(a0), .v0(v0), .r0(r0),
        .a1(a1), .v1(v1), .r1(r1),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_src(y_src),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readies and the scoreboard at the
    // falling edge, then check the registered state just after the rising edge.
    task automatic apply_vec(input vec_t v, input string name);
        logic [8:0] exp_beat;
        v0 = v.v0; a0 = v.a0; v1 = v.v1; a1 = v.a1; y_ready = v.yr;
        @(negedge clk);
        check({name, ".ready"}, {30'd0, r0, r1}, {30'd0, v.e_r0, v.e_r1});
        if (y_valid && y_ready) begin
            if (sb.size() == 0) begin
                check({name, ".sb_underflow"}, 32'd0, 32'd1);
            end else begin
                exp_beat = sb.pop_front();
                check({name, ".beat"}, {23'd0, y_src, y}, {23'd0, exp_beat});
            end
        end
        if (v.e_r0) sb.push_back({1'b0, v.a0});
        if (v.e_r1) sb.push_back({1'b1, v.a1});
        @(posedge clk);
        #1;
        check({name, ".state"}, {6'd0, y_valid, y, y_src, cnt0, cnt1},
              {6'd0, v.e_yv, v.e_y, v.e_src, v.e_c0, v.e_c1});
    endtask

    // One reset cycle with both channels requesting; readies must stay low.
    task automatic reset_cycle(input logic yr);
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 8'hE1; a1 = 8'hE2; y_ready = yr;
        @(negedge clk);
        check("reset.ready", {30'd0, r0, r1}, 32'd0);
        @(posedge clk);
        #1;
        check("reset.state", {6'd0, y_valid, y, y_src, cnt0, cnt1}, 32'd0);
        sb.delete();
        rst = 1'b0;
    endtask

    vec_t tbl[12];
    vec_t vv;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; y_ready = 1'b0;

        //            v0    a0     v1    a1     yr    er0   er1   eyv   ey     esrc  c0     c1
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'd1, 8'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd1, 8'd0};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd1, 8'd1};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd2, 8'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'd2, 8'd2};
        tbl[5]  = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 8'd3, 8'd2};
        tbl[6]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'd4, 8'd2};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'd4, 8'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'd4, 8'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'd4, 8'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'd4, 8'd3};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 8'd4, 8'd3};

        // Reset, then single source, idle drain, ties, single requesters,
        // and a three-cycle backpressure stall with channel 1 pending.
        @(posedge clk);
        #1;
        reset_cycle(1'b1);
        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset mid-stream: beat 0x77 stalled in the output register.
        apply_vec('{1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'd5, 8'd3}, "load77");
        apply_vec('{1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'd5, 8'd3}, "stall77");
        reset_cycle(1'b0);

        // Tie right after reset: channel 0 first, then strict alternation.
        apply_vec('{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 8'd0}, "tie1");
        apply_vec('{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd1, 8'd1}, "tie2");
        apply_vec('{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd2, 8'd1}, "tie3");
        apply_vec('{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'd2, 8'd2}, "tie4");
        apply_vec('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 8'd2, 8'd2}, "tie_drain");

        // Counter wrap: 256 channel-0 beats from reset bring cnt0 back to 0.
        reset_cycle(1'b1);
        for (int i = 0; i < 256; i++) begin
            vv = '{1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 8'(i + 1), 8'd0};
            apply_vec(vv, "wrap");
        end
        apply_vec('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'd0, 8'd0}, "wrap_drain");
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/merge_2_1_rr.md
MERGE_2_1_RR -- requirements
Module: merge_2_1_rr

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a0  input  WIDTH  channel-0 data; produced by demux output y[0] path.
REQ-005 v0  input  1  channel-0 valid.
REQ-006 r0  output  1  channel-0 ready.
REQ-007 a1  input  WIDTH  channel-1 data; produced by demux output y[1] path.
REQ-008 v1  input  1  channel-1 valid.
REQ-009 r1  output  1  channel-1 ready.
REQ-010 y  output  WIDTH  merged output data, registered.
REQ-011 y_valid  output  1  output valid, registered.
REQ-012 y_ready  input  1  downstream ready.
REQ-013 y_src  output  1  source channel of the beat on y (0 or 1), registered.
REQ-014 cnt0  output  8  count of beats accepted from channel 0.
REQ-015 cnt1  output  8  count of beats accepted from channel 1.

Function
REQ-016 Internal load enable: ld = !y_valid || y_ready (output register empty or draining this cycle).
REQ-017 Internal state: last, 1 bit, the channel granted most recently.
REQ-018 Grant, combinational:
- only v0 high -> channel 0
- only v1 high -> channel 1
- both high -> channel !last
- neither high -> no grant
REQ-019 r0 = ld && rst==0 && grant==channel 0; r1 = ld && rst==0 && grant==channel 1; never both high in one cycle.
REQ-020 Transfer on channel k occurs when vk && rk at the rising edge.
- Next cycle: y = ak, y_src = k, y_valid = 1, last = k, cntk increments by 1.
REQ-021 Latency: exactly 1 cycle from input transfer to y_valid.
- Throughput: one beat per cycle while y_ready stays high.
REQ-022 When ld is high and no transfer occurs, y_valid clears to 0; y and y_src hold their previous values.
REQ-023 When y_valid && !y_ready:
- y, y_src and y_valid hold.
- r0 = r1 = 0.
- No counter changes.
REQ-024 Fairness: with v0 and v1 held continuously high and y_ready high, grants alternate 0,1,0,1,...; neither channel waits more than one beat.
REQ-025 Counters are 8-bit unsigned and wrap 255 -> 0 with no flag.
REQ-026 Inputs ak are sampled only on a transfer cycle; data on a non-granted channel is not consumed and stays pending for that channel.
REQ-027 Valid-held rule: the block requires vk, once asserted, to stay high with ak stable until transfer; it does not itself check this.

Reset
REQ-028 While rst is high at a rising edge, the next state is:
- y_valid = 0, y = 0, y_src = 0
- last = 1, so channel 0 wins the first tie
- cnt0 = 0, cnt1 = 0
REQ-029 r0 and r1 are 0 in every cycle rst is high.
REQ-030 Reset mid-operation discards any beat held in the output register; no transfer is counted in a reset cycle.
REQ-031 First cycle after rst deasserts: normal arbitration per REQ-018.

Verification
REQ-032 Single source: reset, then v0=1, a0=8'hA5, v1=0, y_ready=1 for one cycle -> next cycle y=8'hA5, y_src=0, y_valid=1, cnt0=1, cnt1=0.
REQ-033 Tie after reset: v0=v1=1, a0=8'h11, a1=8'h22, y_ready=1 held for 4 cycles -> y sequence 11,22,11,22; y_src 0,1,0,1; cnt0=2, cnt1=2.
REQ-034 Backpressure: load one beat 8'h3C, then y_ready=0 for 3 cycles with v1=1 -> y=8'h3C and y_valid=1 held; r0=r1=0; counters frozen. Then y_ready=1 -> channel-1 beat appears on the next cycle.
REQ-035 Counter wrap: 256 channel-0 transfers from reset -> cnt0 returns to 0; cnt1 stays 0.
REQ-036 Reset mid-stream: y_valid=1 holding 8'h77 with y_ready=0, assert rst one cycle -> y_valid=0, y=0, cnt0=cnt1=0, r0=r1=0 during reset. A tie afterwards grants channel 0 first.
REQ-037 Idle drain: one beat transferred, then v0=v1=0 with y_ready=1 -> y_valid drops to 0 one cycle after the beat is taken; y holds its last value.
